pulse_shaper_mc: RTL and testbench

PULSE_SHAPER_MC -- requirements
Module: pulse_shaper_mc

---
 rtl/pulse_shaper_mc_pkg.sv | 19 +
 rtl/pulse_shaper_ch.sv | 147 ++++++++++++++
 rtl/pulse_shaper_mc.sv | 57 +++++
 tb/tb_pulse_shaper_mc.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_shaper_mc_pkg.sv
// -----------------------------------------------------------------------------
// pulse_shaper_mc_pkg
// Shared definitions for the multi-channel pulse shaper:
//   state_e     per-channel FSM state encoding (IDLE / DELAY / ACTIVE)
//   NON_RETRIG  retrig_mode value: triggers ignored while the gate is active
//   RETRIG      retrig_mode value: a trigger during the gate reloads the width
// -----------------------------------------------------------------------------
package pulse_shaper_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam logic NON_RETRIG = 1'b0;
  localparam logic RETRIG     = 1'b1;

endpackage

// File: rtl/pulse_shaper_ch.sv
// -----------------------------------------------------------------------------
// pulse_shaper_ch
// One trigger/gate channel: rising-edge detector, IDLE/DELAY/ACTIVE FSM and a
// shared down-counter used for both the delay and the gate width.
//
// Ports
//   sys_clk      clock, rising edge
//   sys_rst      synchronous active-high reset
//   enable       run enable; low forces IDLE with outputs low and no done
//   retrig_mode  NON_RETRIG / RETRIG behaviour while ACTIVE
//   trig_in      trigger level, rising edge significant
//   dly_cfg      delay in clocks, latched at trigger
//   wid_cfg      gate width in clocks, latched at trigger (0 = ignore trigger)
//   gate_out     registered gate pulse
//   busy         registered, high while in DELAY or ACTIVE
//   done         registered one-cycle strobe on the cycle the gate falls
//
// Timing: a rise detected at edge n is captured into the p1 stage and acted on
// by the FSM at edge n+1, so busy rises at n+1 and gate_out at n+1+dly. The
// registered outputs are decoded from the next state so they track the FSM
// state exactly.
// -----------------------------------------------------------------------------
module pulse_shaper_ch
  import pulse_shaper_mc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  input  logic             retrig_mode,
  input  logic             trig_in,
  input  logic [CNT_W-1:0] dly_cfg,
  input  logic [CNT_W-1:0] wid_cfg,
  output logic             gate_out,
  output logic             busy,
  output logic             done
);

  logic             trig_p0;
  logic             vld_p1;
  logic [CNT_W-1:0] dly_p1;
  logic [CNT_W-1:0] wid_p1;

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] wid_lat;
  logic [CNT_W-1:0] wid_lat_nxt;
  logic             done_nxt;
  logic             last;

  // ---- Stage p0 -> p1: edge detect and configuration capture ----
  // The trigger history keeps updating while enable is low; a qualified
  // trigger already folds in enable and the nonzero-width condition.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      trig_p0 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      trig_p0 <= trig_in;
      vld_p1  <= trig_in & ~trig_p0 & enable & (wid_cfg != '0);
    end
  end

  always_ff @(posedge sys_clk) begin
    dly_p1 <= dly_cfg;
    wid_p1 <= wid_cfg;
  end

  // ---- Stage p1 -> outputs: channel FSM ----
  // cnt holds the number of cycles left in the current state, including the
  // one being entered, so a state is left on the edge where cnt is 1.
  assign last = (cnt <= CNT_W'(1));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wid_lat_nxt = wid_lat;
    done_nxt    = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (vld_p1) begin
            wid_lat_nxt = wid_p1;
            if (dly_p1 != '0) begin
              state_nxt = ST_DELAY;
              cnt_nxt   = dly_p1;
            end else begin
              state_nxt = ST_ACTIVE;
              cnt_nxt   = wid_p1;
            end
          end
        end
        ST_DELAY: begin
          if (last) begin
            state_nxt = ST_ACTIVE;
            cnt_nxt   = wid_lat;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          // A retrigger on the final active cycle still extends the gate.
          if (vld_p1 && (retrig_mode == RETRIG)) begin
            cnt_nxt = wid_p1;
          end else if (last) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      gate_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gate_out <= (state_nxt == ST_ACTIVE);
      busy     <= (state_nxt != ST_IDLE);
      done     <= done_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    wid_lat <= wid_lat_nxt;
  end

endmodule

// File: rtl/pulse_shaper_mc.sv
// -----------------------------------------------------------------------------
// pulse_shaper_mc
// CH_NUM independent trigger-to-gate pulse shapers sharing clock, reset,
// enable and retrigger mode.
//
// Parameters
//   CH_NUM  number of channels (1..16)
//   CNT_W   width of the per-channel delay/width counters
//
// Ports
//   sys_clk      clock, rising edge
//   sys_rst      synchronous active-high reset
//   enable       global run enable; low aborts all channels
//   retrig_mode  0 = non-retriggerable, 1 = retriggerable during active gate
//   trig_in      per-channel trigger level [CH_NUM]
//   dly_cfg      per-channel delay, channel i at [i*CNT_W +: CNT_W]
//   wid_cfg      per-channel gate width, same packing
//   gate_out     per-channel gate pulse, registered
//   busy         per-channel DELAY/ACTIVE flag, registered
//   done         per-channel one-cycle end-of-gate strobe, registered
// -----------------------------------------------------------------------------
module pulse_shaper_mc
  import pulse_shaper_mc_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    enable,
  input  logic                    retrig_mode,
  input  logic [CH_NUM-1:0]       trig_in,
  input  logic [CH_NUM*CNT_W-1:0] dly_cfg,
  input  logic [CH_NUM*CNT_W-1:0] wid_cfg,
  output logic [CH_NUM-1:0]       gate_out,
  output logic [CH_NUM-1:0]       busy,
  output logic [CH_NUM-1:0]       done
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pulse_shaper_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .enable     (enable),
      .retrig_mode(retrig_mode),
      .trig_in    (trig_in[i]),
      .dly_cfg    (dly_cfg[i*CNT_W +: CNT_W]),
      .wid_cfg    (wid_cfg[i*CNT_W +: CNT_W]),
      .gate_out   (gate_out[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule

// File: tb/tb_pulse_shaper_mc.sv
// -----------------------------------------------------------------------------
// tb_pulse_shaper_mc
// Self-checking bench for pulse_shaper_mc. Edges are numbered by cyc (value of
// cyc after edge e is e); inputs change and outputs are sampled on the falling
// edge. Expected pulses {channel, gate first/last edge, gate length, busy
// first edge, done edge} are queued when triggers are driven; a monitor turns
// each done strobe into an observed record that the tasks match against them.
// -----------------------------------------------------------------------------
module tb_pulse_shaper_mc;

  localparam int CH_NUM = 4;
  localparam int CNT_W  = 8;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst = 1'b1;
  logic                    enable = 1'b1;
  logic                    retrig_mode = 1'b0;
  logic [CH_NUM-1:0]       trig_in = '0;
  logic [CH_NUM*CNT_W-1:0] dly_cfg = '0;
  logic [CH_NUM*CNT_W-1:0] wid_cfg = '0;
  logic [CH_NUM-1:0]       gate_out;
  logic [CH_NUM-1:0]       busy;
  logic [CH_NUM-1:0]       done;

  typedef struct packed {
    int ch;
    int gs;
    int ge;
    int gl;
    int bs;
    int dc;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int m_gs[CH_NUM];
  int m_ge[CH_NUM];
  int m_gl[CH_NUM];
  int m_bs[CH_NUM];
  int gate_tot[CH_NUM];
  int busy_tot[CH_NUM];
  int done_cnt[CH_NUM];
  logic [CH_NUM-1:0] gq = '0;
  logic [CH_NUM-1:0] bq = '0;

  pulse_shaper_mc #(
    .CH_NUM(CH_NUM),
    .CNT_W (CNT_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .enable     (enable),
    .retrig_mode(retrig_mode),
    .trig_in    (trig_in),
    .dly_cfg    (dly_cfg),
    .wid_cfg    (wid_cfg),
    .gate_out   (gate_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
    end
  end

  // Output monitor: builds one record per done strobe.
  initial begin
    forever begin
      @(negedge sys_clk);
      for (int i = 0; i < CH_NUM; i++) begin
        if (gate_out[i] === 1'b1 && gq[i] !== 1'b1) begin
          m_gs[i] = cyc;
          m_gl[i] = 0;
        end
        if (gate_out[i] === 1'b1) begin
          m_gl[i]++;
          m_ge[i] = cyc;
          gate_tot[i]++;
        end
        if (busy[i] === 1'b1 && bq[i] !== 1'b1) m_bs[i] = cyc;
        if (busy[i] === 1'b1) busy_tot[i]++;
        if (done[i] === 1'b1) begin
          obs_q.push_back('{i, m_gs[i], m_ge[i], m_gl[i], m_bs[i], cyc});
          done_cnt[i]++;
        end
      end
      gq = gate_out;
      bq = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic set_cfg(input int ch, input int d, input int w);
    dly_cfg[ch*CNT_W +: CNT_W] = CNT_W'(d);
    wid_cfg[ch*CNT_W +: CNT_W] = CNT_W'(w);
  endtask

  // Expected single pulse for a rise detected at edge n.
  task automatic push_pulse(input int ch, input int n, input int d, input int w);
    exp_q.push_back('{ch, n + 1 + d, n + d + w, w, n + 1, n + d + w + 1});
  endtask

  task automatic take_obs(input int ch, output bit found, output pulse_t o);
    found = 1'b0;
    o = '0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].ch == ch) begin
        o = obs_q[i];
        obs_q.delete(i);
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    pulse_t e, o;
    bit found;
    int n;
    sys_rst = 1'b1;
    tick(3);
    checks++;
    if ({gate_out, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gate=%b busy=%b done=%b, required all 0", gate_out, busy, done);
    end
    // Trigger already high when reset releases counts as a rise.
    set_cfg(0, 0, 2);
    trig_in[0] = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    n = cyc + 1;
    push_pulse(0, n, 0, 2);
    tick(5);
    trig_in[0] = 1'b0;
    tick(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      take_obs(e.ch, found, o);
      checks++;
      if (!found || o !== e) begin
        errors++;
        $display("FAIL reset_release ch%0d: got found=%0b gs=%0d ge=%0d len=%0d bs=%0d done=%0d, required gs=%0d ge=%0d len=%0d bs=%0d done=%0d",
                 e.ch, found, o.gs, o.ge, o.gl, o.bs, o.dc, e.gs, e.ge, e.gl, e.bs, e.dc);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_release_extra: got %0d unexpected pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_basic();
    pulse_t e, o;
    bit found;
    int n;
    retrig_mode = 1'b0;
    set_cfg(0, 0, 5);
    trig_in[0] = 1'b1;
    n = cyc + 1;
    push_pulse(0, n, 0, 5);
    tick(2);
    trig_in[0] = 1'b0;
    tick(10);
    // Delayed pulse; config change and a second rise during DELAY have no effect.
    set_cfg(1, 3, 2);
    trig_in[1] = 1'b1;
    n = cyc + 1;
    push_pulse(1, n, 3, 2);
    tick(1);
    trig_in[1] = 1'b0;
    set_cfg(1, 0, 7);
    tick(1);
    trig_in[1] = 1'b1;
    tick(2);
    trig_in[1] = 1'b0;
    tick(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      take_obs(e.ch, found, o);
      checks++;
      if (!found || o !== e) begin
        errors++;
        $display("FAIL basic ch%0d: got found=%0b gs=%0d ge=%0d len=%0d bs=%0d done=%0d, required gs=%0d ge=%0d len=%0d bs=%0d done=%0d",
                 e.ch, found, o.gs, o.ge, o.gl, o.bs, o.dc, e.gs, e.ge, e.gl, e.bs, e.dc);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL basic_extra: got %0d unexpected pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_retrig();
    pulse_t e, o;
    bit found;
    int n;
    set_cfg(2, 0, 4);
    // Rises at n and n+3, retriggerable: one continuous gate n+1..n+7.
    retrig_mode = 1'b1;
    trig_in[2] = 1'b1;
    n = cyc + 1;
    exp_q.push_back('{2, n + 1, n + 7, 7, n + 1, n + 8});
    tick(1);
    trig_in[2] = 1'b0;
    tick(2);
    trig_in[2] = 1'b1;
    tick(1);
    trig_in[2] = 1'b0;
    tick(12);
    // Same stimulus, non-retriggerable: second rise ignored.
    retrig_mode = 1'b0;
    trig_in[2] = 1'b1;
    n = cyc + 1;
    push_pulse(2, n, 0, 4);
    tick(1);
    trig_in[2] = 1'b0;
    tick(2);
    trig_in[2] = 1'b1;
    tick(1);
    trig_in[2] = 1'b0;
    tick(12);
    // Rise on the last gate-high edge ignored; rise two edges later accepted.
    trig_in[2] = 1'b1;
    n = cyc + 1;
    push_pulse(2, n, 0, 4);
    push_pulse(2, n + 6, 0, 4);
    tick(1);
    trig_in[2] = 1'b0;
    tick(3);
    trig_in[2] = 1'b1;
    tick(1);
    trig_in[2] = 1'b0;
    tick(1);
    trig_in[2] = 1'b1;
    tick(1);
    trig_in[2] = 1'b0;
    tick(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      take_obs(e.ch, found, o);
      checks++;
      if (!found || o !== e) begin
        errors++;
        $display("FAIL retrig ch%0d: got found=%0b gs=%0d ge=%0d len=%0d bs=%0d done=%0d, required gs=%0d ge=%0d len=%0d bs=%0d done=%0d",
                 e.ch, found, o.gs, o.ge, o.gl, o.bs, o.dc, e.gs, e.ge, e.gl, e.bs, e.dc);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL retrig_extra: got %0d unexpected pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_held_zero();
    pulse_t e, o;
    bit found;
    int n, g0, b0, d0;
    retrig_mode = 1'b0;
    set_cfg(3, 1, 3);
    trig_in[3] = 1'b1;
    n = cyc + 1;
    push_pulse(3, n, 1, 3);
    tick(50);
    trig_in[3] = 1'b0;
    tick(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      take_obs(e.ch, found, o);
      checks++;
      if (!found || o !== e) begin
        errors++;
        $display("FAIL held_high ch%0d: got found=%0b gs=%0d ge=%0d len=%0d bs=%0d done=%0d, required gs=%0d ge=%0d len=%0d bs=%0d done=%0d",
                 e.ch, found, o.gs, o.ge, o.gl, o.bs, o.dc, e.gs, e.ge, e.gl, e.bs, e.dc);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL held_high_extra: got %0d unexpected pulses, required 0", obs_q.size());
      obs_q.delete();
    end
    // Zero width: trigger ignored entirely.
    g0 = gate_tot[3];
    b0 = busy_tot[3];
    d0 = done_cnt[3];
    set_cfg(3, 0, 0);
    trig_in[3] = 1'b1;
    tick(2);
    trig_in[3] = 1'b0;
    tick(10);
    checks++;
    if (gate_tot[3] != g0 || busy_tot[3] != b0) begin
      errors++;
      $display("FAIL zero_width_gate: got gate cycles=%0d busy cycles=%0d, required 0 and 0", gate_tot[3] - g0, busy_tot[3] - b0);
    end
    checks++;
    if (done_cnt[3] != d0) begin
      errors++;
      $display("FAIL zero_width_done: got %0d done strobes, required 0", done_cnt[3] - d0);
    end
  endtask

  task automatic test_abort();
    int d0, g1, d1;
    retrig_mode = 1'b0;
    d0 = done_cnt[0];
    set_cfg(0, 0, 10);
    trig_in[0] = 1'b1;
    tick(1);
    trig_in[0] = 1'b0;
    tick(3);
    checks++;
    if (gate_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_gate: got gate=%b, required 1", gate_out[0]);
    end
    enable = 1'b0;
    tick(1);
    checks++;
    if (gate_out[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got gate=%b busy=%b done=%b, required 0 0 0", gate_out[0], busy[0], done[0]);
    end
    enable = 1'b1;
    tick(15);
    checks++;
    if (done_cnt[0] != d0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done strobes, required 0", done_cnt[0] - d0);
      obs_q.delete();
    end
    // Reset while channel 1 is in DELAY.
    set_cfg(1, 5, 3);
    trig_in[1] = 1'b1;
    tick(1);
    trig_in[1] = 1'b0;
    tick(2);
    checks++;
    if (busy[1] !== 1'b1 || gate_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_delay: got busy=%b gate=%b, required 1 0", busy[1], gate_out[1]);
    end
    sys_rst = 1'b1;
    tick(1);
    checks++;
    if ({gate_out, busy, done} !== '0) begin
      errors++;
      $display("FAIL rst_mid_delay: got gate=%b busy=%b done=%b, required all 0", gate_out, busy, done);
    end
    sys_rst = 1'b0;
    g1 = gate_tot[1];
    d1 = done_cnt[1];
    tick(20);
    checks++;
    if (gate_tot[1] != g1 || done_cnt[1] != d1) begin
      errors++;
      $display("FAIL rst_no_pulse: got gate cycles=%0d done=%0d, required 0 and 0", gate_tot[1] - g1, done_cnt[1] - d1);
    end
  endtask

  task automatic test_simultaneous();
    pulse_t e, o;
    bit found;
    int n;
    int w[CH_NUM];
    w = '{1, 2, 3, 255};
    retrig_mode = 1'b0;
    for (int i = 0; i < CH_NUM; i++) set_cfg(i, 0, w[i]);
    trig_in = '1;
    n = cyc + 1;
    for (int i = 0; i < CH_NUM; i++) push_pulse(i, n, 0, w[i]);
    tick(2);
    trig_in = '0;
    tick(265);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      take_obs(e.ch, found, o);
      checks++;
      if (!found || o !== e) begin
        errors++;
        $display("FAIL simultaneous ch%0d: got found=%0b gs=%0d ge=%0d len=%0d bs=%0d done=%0d, required gs=%0d ge=%0d len=%0d bs=%0d done=%0d",
                 e.ch, found, o.gs, o.ge, o.gl, o.bs, o.dc, e.gs, e.ge, e.gl, e.bs, e.dc);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL simultaneous_extra: got %0d unexpected pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retrig();
    test_held_zero();
    test_abort();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
